uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, input clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, reset baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per TX/RX FIFO, power of two, >=2.
REQ-004 SHALL have ports: clk  in  1  clock; rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: sel  in  1  IO decode select; addr  in  2  register word index.
REQ-006 SHALL have ports: wdata  in  32  write data; wmask  in  4  byte write mask, write strobe = sel & |wmask.
REQ-007 SHALL have ports: rstrb  in  1  read strobe, effective only with sel; rdata  out  32  registered read data.
REQ-008 SHALL have ports: rx  in  1  async serial input; tx  out  1  serial output; irq  out  1  RX data available.

Function
REQ-009 addr 0 TXDATA write SHALL push wdata[7:0] into TX FIFO if not full; if full, byte dropped, no flag change.
REQ-010 addr 0 read SHALL return 0.
REQ-011 addr 1 RXDATA read SHALL return {23'b0, valid, byte}; if RX FIFO non-empty, valid=1, head byte returned and popped; if empty, valid=0, byte=0, no pop.
REQ-012 addr 2 STATUS read: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 tx_busy, bit5 rx_overrun, bit6 frame_err, bit9 tx_full, others 0.
REQ-013 addr 2 write with wdata[5]=1 / wdata[6]=1 SHALL clear rx_overrun / frame_err; other bits ignored.
REQ-014 addr 3 DIV read SHALL return {16'b0, div}; write with wmask[1:0]!=0 SHALL load div from wdata[15:0], clamped to min 4.
REQ-015 rdata SHALL update on the clk edge where sel & rstrb is sampled (valid the following cycle); otherwise hold its value.
REQ-016 TX frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit div cycles; tx=1 when idle.
REQ-017 TX FSM states IDLE, START, DATA, STOP; IDLE->START on the edge after TX FIFO non-empty (pop same edge); STOP->START directly if FIFO non-empty, else IDLE.
REQ-018 tx_busy SHALL be 1 in any state other than IDLE.
REQ-019 rx SHALL pass a 2-flop synchronizer before use; no other logic on raw rx.
REQ-020 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synced falling edge.
REQ-021 RX SHALL sample start at div/2 cycles; if 1, return to IDLE (glitch reject); data bits then sampled every div cycles.
REQ-022 RX stop sample 0 SHALL set frame_err and discard byte; stop 1 with RX FIFO full (and no same-cycle pop) SHALL set rx_overrun and discard byte.
REQ-023 div SHALL be latched per frame at START entry (TX and RX independently); DIV writes mid-frame affect next frame only.
REQ-024 Simultaneous push and pop on a FIFO SHALL both succeed, including when full (count unchanged, no overrun) or empty-with-push (pop ignored, push succeeds).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 Sticky flag set and clear in the same cycle: set wins.
REQ-027 irq SHALL equal registered !rx_empty.

Reset
REQ-028 On rstn=0 at a clk edge: FIFOs empty, both FSMs IDLE, tx=1, rdata=0, irq=0, flags 0, div=CLK_FREQ_HZ/BAUD_RATE (104 default).
REQ-029 Reset mid-frame SHALL abort: tx=1 the cycle after, partial RX byte discarded, no flags set.

Verification
REQ-030 Reset then read DIV and STATUS -> rdata 0x68 next cycle, STATUS 0x006 (tx_empty, rx_empty).
REQ-031 div=4, write 0xA5 to TXDATA -> tx line 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_busy 1 for 40 cycles then 0.
REQ-032 div=4, write FIFO_DEPTH+1 bytes back-to-back -> first FIFO_DEPTH(+1 popped to shifter) transmitted in order, excess dropped, frames contiguous.
REQ-033 div=4, drive 0x3C on rx with loopback -> irq=1, RXDATA read returns 0x13C, next read 0x000, irq=0.
REQ-034 Send FIFO_DEPTH+1 frames without reading -> rx_full=1, rx_overrun=1; write STATUS 0x20 -> rx_overrun=0; stop bit 0 frame -> frame_err=1, no push.
REQ-035 Pull rstn low during TX DATA bit 3 -> tx=1 next cycle, STATUS 0x006 after release.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor and RX-available irq
module uart_mmio #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] div_q, div_d, tx_div_q, tx_div_d, rx_div_q, rx_div_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] tx_mem_d [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_n_q, tx_n_d, rx_n_q, rx_n_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic tx_q, tx_d, irq_q, ovr_q, ovr_d, ferr_q, ferr_d, rx_s1_q, rx_s2_q, rx_p_q;
  logic we, re, tx_push, tx_pop, rx_push, rx_pop, ovr_set, ferr_set;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy, tx_last, rx_last, rx_half;
  logic unused;
  always_comb begin
    we = sel & |wmask;
    re = sel & rstrb;
    tx_full = tx_n_q == FULL;
    tx_empty = tx_n_q == '0;
    rx_full = rx_n_q == FULL;
    rx_empty = rx_n_q == '0;
    tx_busy = tx_st_q != IDLE;
    tx_last = tx_cnt_q == tx_div_q - 16'd1;
    rx_last = rx_cnt_q == rx_div_q - 16'd1;
    rx_half = rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1;
    rx_pop = re && addr == 2'd1 && !rx_empty;
    status = {22'b0, tx_full, 2'b0, ferr_q, ovr_q, tx_busy, rx_full, rx_empty, tx_empty, tx_full};
  end
  always_comb begin
    tx_st_d = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_div_d = tx_div_q;
    tx_d = tx_q;
    tx_pop = 1'b0;
    tx_cnt_d = (tx_st_q == IDLE || tx_last) ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_st_q)
      START: if (tx_last) begin
        tx_st_d = DATA;
        tx_d = tx_sh_q[0];
        tx_bit_d = 3'd0;
      end
      DATA: if (tx_last) begin
        tx_sh_d = {1'b0, tx_sh_q[7:1]};
        tx_d = tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
        tx_st_d = tx_bit_q == 3'd7 ? STOP : DATA;
        tx_bit_d = tx_bit_q + 3'd1;
      end
      STOP: if (tx_last) begin
        tx_st_d = IDLE;
        tx_d = 1'b1;
      end
      default: ;
    endcase
    if ((tx_st_q == IDLE || (tx_st_q == STOP && tx_last)) && !tx_empty) begin
      tx_pop = 1'b1;
      tx_st_d = START;
      tx_d = 1'b0;
      tx_sh_d = tx_mem_q[tx_rp_q];
      tx_div_d = div_q;
    end
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_div_d = rx_div_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_push = 1'b0;
    ovr_set = 1'b0;
    ferr_set = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_p_q && !rx_s2_q) begin
          rx_st_d = START;
          rx_div_d = div_q;
        end
      end
      START: if (rx_half) begin
        rx_cnt_d = 16'd0;
        rx_bit_d = 3'd0;
        rx_st_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_last) begin
        rx_cnt_d = 16'd0;
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = rx_bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (rx_last) begin
        rx_cnt_d = 16'd0;
        rx_st_d = IDLE;
        ferr_set = !rx_s2_q;
        ovr_set = rx_s2_q && rx_full && !rx_pop;
        rx_push = rx_s2_q && (!rx_full || rx_pop);
      end
      default: ;
    endcase
  end
  always_comb begin
    tx_push = we && addr == 2'd0 && (!tx_full || tx_pop);
    tx_mem_d = tx_mem_q;
    if (tx_push) tx_mem_d[tx_wp_q] = wdata[7:0];
    rx_mem_d = rx_mem_q;
    if (rx_push) rx_mem_d[rx_wp_q] = rx_sh_q;
    tx_wp_d = tx_wp_q + AW'(tx_push);
    tx_rp_d = tx_rp_q + AW'(tx_pop);
    tx_n_d = tx_n_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d = rx_wp_q + AW'(rx_push);
    rx_rp_d = rx_rp_q + AW'(rx_pop);
    rx_n_d = rx_n_q + CW'(rx_push) - CW'(rx_pop);
    div_d = (we && addr == 2'd3 && |wmask[1:0]) ? (wdata[15:0] < 16'd4 ? 16'd4 : wdata[15:0]) : div_q;
    ovr_d = ovr_set | (ovr_q & ~(we && addr == 2'd2 && wdata[5]));
    ferr_d = ferr_set | (ferr_q & ~(we && addr == 2'd2 && wdata[6]));
    rdata_d = !re ? rdata_q :
              addr == 2'd1 ? {23'b0, !rx_empty, rx_empty ? 8'h00 : rx_mem_q[rx_rp_q]} :
              addr == 2'd2 ? status :
              addr == 2'd3 ? {16'b0, div_q} : 32'b0;
  end
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
    if (!rstn) begin
      tx_st_q <= IDLE;
      rx_st_q <= IDLE;
      div_q <= DIV_RST;
      tx_div_q <= DIV_RST;
      rx_div_q <= DIV_RST;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_n_q <= '0;
      rx_n_q <= '0;
      rdata_q <= '0;
      tx_q <= 1'b1;
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      div_q <= div_d;
      tx_div_q <= tx_div_d;
      rx_div_q <= rx_div_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_n_q <= tx_n_d;
      rx_n_q <= rx_n_d;
      rdata_q <= rdata_d;
      tx_q <= tx_d;
      irq_q <= !rx_empty;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_p_q <= rx_s2_q;
    end
  end
  assign tx = tx_q;
  assign irq = irq_q;
  assign rdata = rdata_q;
  assign unused = ^wdata[31:16];
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench checking uart_mmio register reads and serial TX frames
module tb_uart_mmio;
  localparam int D = 8;
  typedef struct { string n; logic [31:0] v; } exp_t;
  logic clk = 1'b0, rstn = 1'b0, sel = 1'b0, rstrb = 1'b0, rx_drv = 1'b1, loop = 1'b0, rv = 1'b0;
  logic [1:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wmask = '0;
  logic [31:0] rdata;
  logic rx, tx, irq;
  int checks = 0, errors = 0, rst_cnt = 0;
  exp_t rd_exp[$];
  logic [7:0] tx_exp[$];
  assign rx = loop ? tx : rx_drv;
  uart_mmio #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .addr(addr), .wdata(wdata), .wmask(wmask),
    .rstrb(rstrb), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rv <= rstn & sel & rstrb;
  always @(posedge clk) if (!rstn) rst_cnt <= rst_cnt + 1;
  always @(negedge clk) if (rv) begin
    exp_t e;
    checks++;
    if (rd_exp.size() == 0) begin
      errors++;
      $display("FAIL rd_unexpected got=%h", rdata);
    end else begin
      e = rd_exp.pop_front();
      if (rdata !== e.v) begin
        errors++;
        $display("FAIL %s got=%h want=%h", e.n, rdata, e.v);
      end
    end
  end
  initial begin : tx_mon
    logic [39:0] got, want;
    logic [7:0] b;
    int r0;
    bit cont;
    cont = 1'b0;
    forever begin
      @(negedge clk);
      if (cont) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL tx_gap got=%b want=0", tx);
        end
        cont = 1'b0;
      end
      if (tx === 1'b0) begin
        r0 = rst_cnt;
        got[0] = tx;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          got[i] = tx;
        end
        if (rst_cnt != r0) begin
          if (tx_exp.size() > 0) void'(tx_exp.pop_front());
        end else begin
          checks++;
          if (tx_exp.size() == 0) begin
            errors++;
            $display("FAIL tx_frame unexpected got=%h", got);
          end else begin
            b = tx_exp.pop_front();
            for (int i = 0; i < 40; i++) want[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b[(i - 4) / 4];
            if (got !== want) begin
              errors++;
              $display("FAIL tx_frame got=%h want=%h", got, want);
            end
            cont = tx_exp.size() > 0;
          end
        end
      end
    end
  end
  task automatic op(input logic s, input logic r, input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = s;
    rstrb = r;
    addr = a;
    wdata = d;
    wmask = m;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, a, d, 4'hf);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    exp_t x;
    x.n = n;
    x.v = e;
    rd_exp.push_back(x);
    op(1'b1, 1'b1, a, 32'd0, 4'd0);
  endtask
  task automatic send(input logic [7:0] b);
    tx_exp.push_back(b);
    wr(2'd0, {24'd0, b});
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, got, exp);
    end
  endtask
  initial begin
    logic [9:0] f;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rstn = 1'b1;
    rd(2'd3, 32'h68, "div_rst");
    rd(2'd2, 32'h006, "status_rst");
    rd(2'd0, 32'h0, "txdata_rd");
    wr(2'd3, 32'd2);
    rd(2'd3, 32'd4, "div_clamp");
    op(1'b1, 1'b0, 2'd3, 32'h10, 4'b1100);
    rd(2'd3, 32'd4, "div_mask");
    wr(2'd3, 32'hFFFF1234);
    rd(2'd3, 32'h1234, "div_load");
    wr(2'd3, 32'd4);
    send(8'hA5);
    idle(39);
    rd(2'd2, 32'h016, "busy_40");
    idle(1);
    rd(2'd2, 32'h006, "busy_done");
    for (int i = 0; i < D + 3; i++) begin
      if (i <= D) tx_exp.push_back(8'hC0 + 8'(i));
      wr(2'd0, 32'hC0 + i);
    end
    rd(2'd2, 32'h215, "tx_full");
    idle((D + 1) * 40 + 10);
    rd(2'd2, 32'h006, "tx_drained");
    loop = 1'b1;
    send(8'h3C);
    idle(60);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(2'd1, 32'h13C, "rx_byte");
    rd(2'd1, 32'h000, "rx_empty_rd");
    idle(2);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    for (int i = 0; i <= D; i++) send(8'h50 + 8'(i));
    idle((D + 1) * 40 + 20);
    rd(2'd2, 32'h02A, "rx_overrun");
    wr(2'd2, 32'h20);
    rd(2'd2, 32'h00A, "ovr_clear");
    for (int i = 0; i < D; i++) rd(2'd1, 32'h150 + i, "rx_fifo");
    rd(2'd2, 32'h006, "rx_drained");
    loop = 1'b0;
    f = {1'b0, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      idle(4);
    end
    rx_drv = 1'b1;
    idle(10);
    rd(2'd2, 32'h046, "frame_err");
    chk("ferr_no_push", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h40);
    rd(2'd2, 32'h006, "ferr_clear");
    send(8'h00);
    idle(17);
    chk("tx_bit3", {31'd0, tx}, 32'd0);
    rstn = 1'b0;
    idle(1);
    chk("rst_abort_tx", {31'd0, tx}, 32'd1);
    rstn = 1'b1;
    rd(2'd2, 32'h006, "status_after_rst");
    rd(2'd3, 32'h68, "div_after_rst");
    idle(45);
    chk("tx_exp_left", 32'(tx_exp.size()), 32'd0);
    chk("rd_exp_left", 32'(rd_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
